// File: rtl/uart_rxblock.sv
// uart_rxblock: 16x oversampled 8N1 UART receiver with valid/ack handshake, framing-error and overrun flags.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 vote at cnt 6/7/8 (decisions move one edge later).
module uart_rxblock (
  input  logic       clk16,
  input  logic       rst_n,
  input  logic       serial_in,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t     state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d, rx_busy_q, rx_busy_d;
  logic       frame_err_q, frame_err_d, overrun_q, overrun_d;
  logic       sin, smp, dec;
  assign sin = sync_q[1];
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q, hist_d;
  always_comb begin
    hist_d = hist_q;
    if (cnt_q == 4'd6) hist_d[0] = sin;
    if (cnt_q == 4'd7) hist_d[1] = sin;
  end
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) hist_q <= 2'b11;
    else        hist_q <= hist_d;
  end
  assign dec = cnt_q == 4'd8;
  assign smp = (hist_q[0] & hist_q[1]) | (hist_q[0] & sin) | (hist_q[1] & sin);
`else
  assign dec = cnt_q == 4'd7;
  assign smp = sin;
`endif
  always_comb begin
    sync_d      = {sync_q[0], serial_in};
    state_d     = state_q;
    cnt_d       = (state_q == IDLE || state_q == BRK) ? 4'd0 : cnt_q + 4'd1;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_ack ? 1'b0 : rx_valid_q;
    overrun_d   = (rx_ack && rx_valid_q) ? 1'b0 : overrun_q;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE:  if (!sin) state_d = START;
      START: begin
        if (dec && smp) state_d = IDLE;
        else if (cnt_q == 4'd15) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (dec) shreg_d[idx_q] = smp;
        if (cnt_q == 4'd15) begin
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      STOP: begin
        if (dec) begin
          state_d = smp ? IDLE : BRK;
          if (!smp) frame_err_d = 1'b1;
          else if (!rx_valid_q || rx_ack) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
          end else overrun_d = 1'b1;
        end
      end
      // a held-low line must return high before another start can be seen
      BRK:     if (sin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rx_busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= 4'd0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_busy_q   <= rx_busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_uart_rxblock.sv
// tb_uart_rxblock: directed frames against an edge-arithmetic model of uart_rxblock outputs.
module tb_uart_rxblock;
`ifdef UART_RX_MAJORITY_EN
  localparam int M = 1;
`else
  localparam int M = 0;
`endif
  localparam int LAT = 154 + M;
  localparam int K_GOOD = 0, K_FERR = 1, K_GLITCH = 2;
  logic       clk16 = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_in = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_busy, frame_err, overrun;
  int checks = 0, failures = 0;
  int cyc = 0;
  int ev_n = -1000, ev_end = -1000, ev_kind = K_GOOD;
  logic [7:0] ev_d = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic m_valid = 1'b0, m_busy = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  bit auto_ack = 1'b0;
  logic pv = 1'b0;
  int ferr_cnt = 0;
  int rise_c[$];
  logic [7:0] rise_d[$];
  uart_rxblock dut (
    .clk16(clk16), .rst_n(rst_n), .serial_in(serial_in), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_busy(rx_busy),
    .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk16 = ~clk16;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", nm, act, exp, cyc);
    end
  endtask
  // Model: a frame whose line falls at edge n decides at n+LAT; busy spans [n+2, end).
  always @(posedge clk16) begin
    cyc++;
    if (!rst_n) begin
      m_data = 8'h00; m_valid = 1'b0; m_busy = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      ev_n = -1000; ev_end = -1000;
    end else begin
      m_ferr = (cyc == ev_n + LAT) && ev_kind == K_FERR;
      if (rx_ack && m_valid) m_ovr = 1'b0;
      if ((cyc == ev_n + LAT) && ev_kind == K_GOOD) begin
        if (!m_valid || rx_ack) begin
          m_data = ev_d; m_valid = 1'b1;
        end else m_ovr = 1'b1;
      end else if (rx_ack) m_valid = 1'b0;
      m_busy = (cyc >= ev_n + 2) && (cyc < ev_end);
    end
  end
  always @(negedge clk16) begin
    if (!rst_n) begin
      chk("rst_rx_data", rx_data, 0);
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_busy", rx_busy, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
    end else begin
      chk("rx_data", rx_data, m_data);
      chk("rx_valid", rx_valid, m_valid);
      chk("rx_busy", rx_busy, m_busy);
      chk("frame_err", frame_err, m_ferr);
      chk("overrun", overrun, m_ovr);
    end
    if (rx_valid && !pv) begin
      rise_c.push_back(cyc);
      rise_d.push_back(rx_data);
    end
    pv = rx_valid;
    if (frame_err) ferr_cnt++;
  end
  task automatic tick();
    @(posedge clk16);
    #2;
    if (auto_ack) rx_ack = rx_valid;
  endtask
  task automatic send(input logic [7:0] b, input logic stop, input bit spike, input int nt);
    logic [9:0] fr;
    fr      = {stop, b, 1'b0};
    ev_n    = cyc + 1;
    ev_d    = b;
    ev_kind = stop ? K_GOOD : K_FERR;
    ev_end  = stop ? ev_n + LAT : 32'h3fff_ffff;
    for (int i = 0; i < nt; i++) begin
      serial_in = fr[i / 16] ^ logic'(spike && (i % 16 == 8));
      tick();
    end
  endtask
  task automatic ack_once();
    rx_ack = 1'b1;
    tick();
    rx_ack = 1'b0;
  endtask
  initial begin
    int nr, fe0, r;
    repeat (3) tick();
    chk("reset_data_lit", rx_data, 8'h00);
    chk("reset_busy_lit", rx_busy, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    nr = rise_c.size();
    send(8'hA5, 1'b1, 1'b0, 160);
    r = (rise_c.size() > nr) ? rise_c[nr] - ev_n : -1;
    chk("a5_valid_edge", r, 154 + M);
    chk("a5_data_lit", rx_data, 8'hA5);
    chk("a5_valid_lit", rx_valid, 1);
    chk("a5_busy_low", rx_busy, 0);
    ack_once();
    chk("a5_ack_clears", rx_valid, 0);
    repeat (10) tick();
    nr = rise_c.size();
    auto_ack = 1'b1;
    send(8'h3C, 1'b1, 1'b0, 160);
    send(8'hFF, 1'b1, 1'b0, 160);
    repeat (10) tick();
    auto_ack = 1'b0;
    rx_ack = 1'b0;
    tick();
    chk("b2b_events", rise_c.size() - nr, 2);
    if (rise_c.size() >= nr + 2) begin
      chk("b2b_spacing", rise_c[nr + 1] - rise_c[nr], 160);
      chk("b2b_first", rise_d[nr], 8'h3C);
      chk("b2b_second", rise_d[nr + 1], 8'hFF);
    end
    send(8'h55, 1'b1, 1'b0, 160);
    send(8'h81, 1'b1, 1'b0, 160);
    repeat (3) tick();
    chk("ovr_data_kept", rx_data, 8'h55);
    chk("ovr_flag", overrun, 1);
    chk("ovr_valid", rx_valid, 1);
    ack_once();
    chk("ovr_ack_valid", rx_valid, 0);
    chk("ovr_ack_flag", overrun, 0);
    repeat (10) tick();
    fe0 = ferr_cnt;
    send(8'h12, 1'b0, 1'b0, 160);
    repeat (40) tick();
    chk("ferr_pulses", ferr_cnt - fe0, 1);
    chk("ferr_break_busy", rx_busy, 1);
    chk("ferr_no_valid", rx_valid, 0);
    chk("ferr_data_kept", rx_data, 8'h55);
    serial_in = 1'b1;
    ev_end = cyc + 3;
    repeat (6) tick();
    chk("break_exit_busy", rx_busy, 0);
    repeat (10) tick();
    ev_n = cyc + 1;
    ev_kind = K_GLITCH;
    ev_end = ev_n + 10 + M;
    serial_in = 1'b0;
    repeat (4) tick();
    serial_in = 1'b1;
    while (cyc < ev_n + 10 + M) tick();
    chk("glitch_busy_clear", rx_busy, 0);
    repeat (10) tick();
    chk("glitch_no_valid", rx_valid, 0);
    send(8'h77, 1'b1, 1'b0, 88);
    rst_n = 1'b0;
    serial_in = 1'b1;
    tick();
    chk("midrst_data", rx_data, 8'h00);
    chk("midrst_busy", rx_busy, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    send(8'h0F, 1'b1, 1'b0, 160);
    chk("after_rst_data", rx_data, 8'h0F);
    chk("after_rst_valid", rx_valid, 1);
    ack_once();
`ifdef UART_RX_MAJORITY_EN
    repeat (5) tick();
    send(8'h5A, 1'b1, 1'b1, 160);
    chk("maj_spike_data", rx_data, 8'h5A);
    chk("maj_spike_valid", rx_valid, 1);
    ack_once();
`endif
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
